// File: rtl/tone_mixer_nco.sv
// tone_mixer_nco: NUM_CH square-tone NCOs with per-channel duty level, mixed to a 1-bit sigma-delta stream; `TONE_SYNC_UPDATE_EN selects wrap-synchronous retune
module tone_mixer_nco #(
  parameter int NUM_CH = 4,
  parameter int ACC_W = 32,
  parameter int VOL_W = 4,
  parameter int CLK_HZ = 125000000,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int MW = $clog2(NUM_CH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             output_enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_chan,
  input  logic [ACC_W-1:0] cfg_tuning,
  input  logic [VOL_W-1:0] cfg_volume,
  output logic             square_wave_out
);
  if (NUM_CH < 1 || NUM_CH > 16 || CLK_HZ < 1) begin : g_bad_cfg
    $error("tone_mixer_nco: unsupported parameter set");
  end
  logic [ACC_W-1:0] phase [NUM_CH];
  logic [ACC_W-1:0] inc [NUM_CH];
  logic [VOL_W-1:0] vol [NUM_CH];
  logic [NUM_CH-1:0] ch_bit;
  logic [MW-1:0] mix_acc, cnt, s;
  logic hi, pending, xfer, commit;
  logic [CH_W-1:0] p_chan;
  logic [ACC_W-1:0] p_tun;
  logic [VOL_W-1:0] p_vol;
  assign xfer = cfg_valid && cfg_ready;
`ifdef TONE_SYNC_UPDATE_EN
  logic sel_wrap, sel_idle, chan_ok;
  // carry-out and idle status of the channel the pending write targets
  always_comb begin
    sel_wrap = 1'b0;
    sel_idle = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_wrap = int'(p_chan) == i ? (phase[i] + inc[i]) < phase[i] : sel_wrap;
      sel_idle = int'(p_chan) == i ? inc[i] == '0 : sel_idle;
    end
  end
  assign chan_ok = int'(p_chan) < NUM_CH;
  assign commit = pending && (!chan_ok || !output_enable || sel_idle || sel_wrap);
  assign cfg_ready = !pending;
`else
  assign commit = pending;
  assign cfg_ready = 1'b1;
`endif
  // popcount of channel bits feeding the first-order sigma-delta sum
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_CH; i++) cnt = cnt + MW'(ch_bit[i]);
    s = mix_acc + cnt;
    hi = s >= MW'(NUM_CH);
  end
  // single-entry config slot; a write is held here until its commit point
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      p_chan <= '0;
      p_tun <= '0;
      p_vol <= '0;
    end else begin
      pending <= xfer || (pending && !commit);
      if (xfer) begin
        p_chan <= cfg_chan;
        p_tun <= cfg_tuning;
        p_vol <= cfg_volume;
      end
    end
  end
  // phase accumulators, registered channel bits, and retune on commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_bit <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        phase[i] <= '0;
        inc[i] <= '0;
        vol[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        phase[i] <= output_enable ? phase[i] + inc[i] : '0;
        ch_bit[i] <= inc[i] != '0 && {1'b0, vol[i]} > phase[i][ACC_W-1 -: VOL_W+1];
        if (commit && int'(p_chan) == i) begin
          inc[i] <= p_tun;
          vol[i] <= p_vol;
        end
      end
    end
  end
  // sigma-delta mixer: emits a 1 and subtracts NUM_CH whenever the sum reaches NUM_CH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_acc <= '0;
      square_wave_out <= 1'b0;
    end else if (!output_enable) begin
      mix_acc <= '0;
      square_wave_out <= 1'b0;
    end else begin
      square_wave_out <= hi;
      mix_acc <= hi ? s - MW'(NUM_CH) : s;
    end
  end
endmodule

// File: tb/tb_tone_mixer_nco.sv
// tb_tone_mixer_nco: randomized directed bench for tone_mixer_nco against an arithmetic reference model
module tb_tone_mixer_nco;
  localparam int N = 4;
  localparam longint unsigned M = 64'h1_0000_0000;
`ifdef TONE_SYNC_UPDATE_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic output_enable = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [1:0] cfg_chan = '0;
  logic [31:0] cfg_tuning = '0;
  logic [3:0] cfg_volume = '0;
  logic square_wave_out;
  int checks = 0;
  int failures = 0;
  longint unsigned m_phase [N];
  longint unsigned m_inc [N];
  int m_vol [N];
  bit m_bit [N];
  int m_acc;
  bit m_out;
  bit m_pend;
  int m_pc;
  longint unsigned m_pt;
  int m_pv;

  always #4 clk = ~clk;

  tone_mixer_nco #(.NUM_CH(N), .ACC_W(32), .VOL_W(4), .CLK_HZ(125000000)) dut (
    .clk(clk), .rst(rst), .output_enable(output_enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_tuning(cfg_tuning), .cfg_volume(cfg_volume),
    .square_wave_out(square_wave_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_phase[i] = 0;
      m_inc[i] = 0;
      m_vol[i] = 0;
      m_bit[i] = 0;
    end
    m_acc = 0;
    m_out = 0;
    m_pend = 0;
    m_pc = 0;
    m_pt = 0;
    m_pv = 0;
  endtask

  function automatic bit m_ready();
    return SYNC ? !m_pend : 1'b1;
  endfunction

  // one clock of the reference: level = top 5 phase bits, density mixer in integers
  task automatic model_step();
    longint unsigned np [N];
    bit nb [N];
    int cnt = 0;
    int sum;
    bit commit, xfer;
    for (int i = 0; i < N; i++) begin
      cnt += int'(m_bit[i]);
      nb[i] = m_inc[i] != 0 && m_vol[i] > int'(m_phase[i] >> 27);
      np[i] = output_enable ? (m_phase[i] + m_inc[i]) % M : 0;
    end
    commit = m_pend && (!SYNC || !output_enable || m_pc >= N || m_inc[m_pc] == 0 ||
                        m_phase[m_pc] + m_inc[m_pc] >= M);
    xfer = cfg_valid && m_ready();
    if (!output_enable) begin
      m_acc = 0;
      m_out = 0;
    end else begin
      sum = m_acc + cnt;
      m_out = sum >= N;
      m_acc = m_out ? sum - N : sum;
    end
    if (commit && m_pc < N) begin
      m_inc[m_pc] = m_pt;
      m_vol[m_pc] = m_pv;
    end
    m_pend = xfer || (m_pend && !commit);
    if (xfer) begin
      m_pc = int'(cfg_chan);
      m_pt = longint'(cfg_tuning);
      m_pv = int'(cfg_volume);
    end
    for (int i = 0; i < N; i++) begin
      m_phase[i] = np[i];
      m_bit[i] = nb[i];
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("out", square_wave_out, m_out);
    check("cfg_ready", cfg_ready, m_ready());
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // leaves cfg_valid high so consecutive calls form a held-valid burst
  task automatic write(input int ch, input logic [31:0] t, input int v);
    bit done = 0;
    cfg_valid = 1'b1;
    cfg_chan = 2'(ch);
    cfg_tuning = t;
    cfg_volume = 4'(v);
    for (int k = 0; k < 5000 && !done; k++) begin
      done = m_ready();
      tick();
    end
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL write_timeout got=%0d exp=1 ch=%0d", done, ch);
    end
  endtask

  function automatic logic [31:0] pick_tuning();
    int r = $urandom_range(0, 5);
    return r == 0 ? 32'h0 : r == 1 ? 32'hFFFF_FFFF : 32'($urandom_range(4000000, 40000000));
  endfunction

  initial begin
    logic [31:0] t;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_out", square_wave_out, 1'b0);
    check("rst_ready", cfg_ready, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < N; i++) write(i, 32'($urandom_range(4000000, 40000000)), 15);
    cfg_valid = 1'b0;
    run(300);
    t = 32'($urandom_range(8000000, 20000000));
    write(0, t, 15);
    for (int i = 1; i < N; i++) write(i, 32'($urandom), 0);
    cfg_valid = 1'b0;
    output_enable = 1'b1;
    run(1500);
    write(0, t, 4);
    cfg_valid = 1'b0;
    run(1500);
    output_enable = 1'b0;
    t = 32'($urandom_range(8000000, 20000000));
    for (int i = 0; i < N; i++) write(i, t, 15);
    cfg_valid = 1'b0;
    tick();
    output_enable = 1'b1;
    run(1500);
    for (int k = 0; k < 30; k++) begin
      output_enable = $urandom_range(0, 7) != 0;
      write($urandom_range(0, N - 1), pick_tuning(), $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) write($urandom_range(0, N - 1), pick_tuning(), 15);
      cfg_valid = 1'b0;
      run($urandom_range(20, 200));
    end
    output_enable = 1'b1;
    for (int i = 0; i < N; i++) write(i, 32'd16000000, 15);
    cfg_valid = 1'b0;
    run(100);
    write(1, 32'd30000000, 9);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", cfg_ready, 1'b1);
    check("arst_out", square_wave_out, 1'b0);
    model_reset();
    cfg_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("arst_hold_out", square_wave_out, 1'b0);
    run(500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
